// File: rtl/mcs8_bus_ctrl.sv
// MCS8 system bus controller.
// Demultiplexes the CPU's time-multiplexed bus using the T-state code and
// latches the address and cycle type. Runs handshaked memory and I/O
// requests, returns read/input data during T3 and stretches the CPU through
// READY_O. An 8-bit timeout guards every outstanding request.
module mcs8_bus_ctrl #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        SYNC_I,
    input  logic [2:0]  STATE_I,
    input  logic [7:0]  BUS_I,
    output logic        READY_O,
    output logic [7:0]  CPU_DATA_O,
    output logic        CPU_DATA_EN_O,
    output logic [13:0] ADDR_O,
    output logic [1:0]  CYCLE_O,
    output logic        MEM_RD_O,
    output logic        MEM_WR_O,
    output logic [7:0]  MEM_WDATA_O,
    input  logic [7:0]  MEM_RDATA_I,
    input  logic        MEM_ACK_I,
    output logic        IO_RD_O,
    output logic        IO_WR_O,
    output logic [4:0]  IO_PORT_O,
    output logic [7:0]  IO_WDATA_O,
    input  logic [7:0]  IO_RDATA_I,
    input  logic        IO_ACK_I,
    input  logic [7:0]  INT_VEC_I,
    output logic        INTA_O,
    output logic        HALT_O,
    output logic        BUS_ERR_O
);

    localparam logic [2:0] ST_T1   = 3'b010;
    localparam logic [2:0] ST_T2   = 3'b100;
    localparam logic [2:0] ST_T3   = 3'b001;
    localparam logic [2:0] ST_T1I  = 3'b110;
    localparam logic [2:0] ST_STOP = 3'b011;
    localparam logic [2:0] ST_WAIT = 3'b000;

    localparam logic [1:0] CYC_PCI = 2'b00;
    localparam logic [1:0] CYC_PCC = 2'b01;
    localparam logic [1:0] CYC_PCR = 2'b10;
    localparam logic [1:0] CYC_PCW = 2'b11;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_IO_REQ = 3'd2,
        S_WR_ARM = 3'd3,
        S_WR_REQ = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_lo, w_lo_nxt;
    logic [13:0] r_addr, w_addr_nxt;
    logic [1:0]  r_cycle, w_cycle_nxt;
    logic        r_mem_rd, w_mem_rd_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;
    logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
    logic        r_io_rd, w_io_rd_nxt;
    logic        r_io_wr, w_io_wr_nxt;
    logic [4:0]  r_io_port, w_io_port_nxt;
    logic [7:0]  r_io_wdata, w_io_wdata_nxt;
    logic [7:0]  r_cpu_data, w_cpu_data_nxt;
    logic        r_cpu_data_en, w_cpu_data_en_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_inta, w_inta_nxt;
    logic        r_halt, w_halt_nxt;
    logic        r_err, w_err_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;

    logic        w_sample;
    logic        w_t1;
    logic        w_t2;
    logic        w_t3;
    logic        w_is_rd;
    logic        w_ack;
    logic        w_tmo;
    logic [7:0]  w_rdata;
    logic [7:0]  w_cnt_inc;
    logic [4:0]  w_port;

    // WAIT samples are treated like non-strobe cycles so no bus state moves.
    assign w_sample  = SYNC_I && (STATE_I != ST_WAIT);
    assign w_t1      = w_sample && ((STATE_I == ST_T1) || (STATE_I == ST_T1I));
    assign w_t2      = w_sample && (STATE_I == ST_T2);
    assign w_t3      = w_sample && (STATE_I == ST_T3);
    assign w_is_rd   = r_mem_rd || r_io_rd;
    assign w_rdata   = r_mem_rd ? MEM_RDATA_I : IO_RDATA_I;
    assign w_ack     = ((r_mem_rd || r_mem_wr) && MEM_ACK_I) || ((r_io_rd || r_io_wr) && IO_ACK_I);
    assign w_cnt_inc = r_cnt + 8'd1;
    // An ACK on the limit edge wins over the timeout.
    assign w_tmo     = !w_ack && (w_cnt_inc == LIMIT);
    assign w_port    = BUS_I[5:1];

    // Next-state and next-output logic for the bus FSM and its datapath.
    always_comb begin
        w_state_nxt       = r_state;
        w_lo_nxt          = r_lo;
        w_addr_nxt        = r_addr;
        w_cycle_nxt       = r_cycle;
        w_mem_rd_nxt      = r_mem_rd;
        w_mem_wr_nxt      = r_mem_wr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_io_rd_nxt       = r_io_rd;
        w_io_wr_nxt       = r_io_wr;
        w_io_port_nxt     = r_io_port;
        w_io_wdata_nxt    = r_io_wdata;
        w_cpu_data_nxt    = r_cpu_data;
        w_cpu_data_en_nxt = r_cpu_data_en;
        w_ready_nxt       = r_ready;
        w_inta_nxt        = r_inta;
        w_halt_nxt        = r_halt;
        w_err_nxt         = r_err;
        w_cnt_nxt         = r_cnt;

        // State-strobe side effects common to every FSM state.
        if (w_t1) begin
            w_lo_nxt          = BUS_I;
            w_inta_nxt        = (STATE_I == ST_T1I);
            w_cpu_data_en_nxt = 1'b0;
        end else begin
            w_lo_nxt = r_lo;
        end

        if (w_t2) begin
            w_addr_nxt  = {BUS_I[5:0], r_lo};
            w_cycle_nxt = BUS_I[7:6];
        end else begin
            w_addr_nxt = r_addr;
        end

        if (w_sample) begin
            w_halt_nxt = (STATE_I == ST_STOP);
        end else begin
            w_halt_nxt = r_halt;
        end

        case (r_state)
            S_IDLE: begin
                if (w_t2) begin
                    case (BUS_I[7:6])
                        CYC_PCI, CYC_PCR: begin
                            if (r_inta) begin
                                // Interrupt fetch: the vector is jammed in, no memory access.
                                w_cpu_data_nxt    = INT_VEC_I;
                                w_cpu_data_en_nxt = 1'b1;
                                w_state_nxt       = S_HOLD;
                            end else begin
                                w_mem_rd_nxt = 1'b1;
                                w_ready_nxt  = 1'b0;
                                w_cnt_nxt    = 8'd0;
                                w_state_nxt  = S_RD_REQ;
                            end
                        end
                        CYC_PCC: begin
                            w_io_port_nxt = w_port;
                            w_ready_nxt   = 1'b0;
                            w_cnt_nxt     = 8'd0;
                            w_state_nxt   = S_IO_REQ;
                            if (w_port < 5'd8) begin
                                w_io_rd_nxt = 1'b1;
                            end else begin
                                w_io_wr_nxt    = 1'b1;
                                w_io_wdata_nxt = r_lo;
                            end
                        end
                        CYC_PCW: begin
                            w_state_nxt = S_WR_ARM;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WR_ARM: begin
                if (w_t3) begin
                    w_mem_wdata_nxt = BUS_I;
                    w_mem_wr_nxt    = 1'b1;
                    w_ready_nxt     = 1'b0;
                    w_cnt_nxt       = 8'd0;
                    w_state_nxt     = S_WR_REQ;
                end else if (w_t1) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WR_ARM;
                end
            end

            S_RD_REQ, S_IO_REQ, S_WR_REQ: begin
                if (w_ack) begin
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_io_rd_nxt  = 1'b0;
                    w_io_wr_nxt  = 1'b0;
                    w_ready_nxt  = 1'b1;
                    if (w_is_rd) begin
                        w_cpu_data_nxt    = w_rdata;
                        w_cpu_data_en_nxt = !w_t1;
                    end else begin
                        w_cpu_data_en_nxt = 1'b0;
                    end
                    w_state_nxt = w_t1 ? S_IDLE : S_HOLD;
                end else if (w_t1) begin
                    // A new cycle began before completion: abort and flag it.
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_io_rd_nxt  = 1'b0;
                    w_io_wr_nxt  = 1'b0;
                    w_ready_nxt  = 1'b1;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_tmo) begin
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                    w_io_rd_nxt  = 1'b0;
                    w_io_wr_nxt  = 1'b0;
                    w_ready_nxt  = 1'b1;
                    w_err_nxt    = 1'b1;
                    if (w_is_rd) begin
                        w_cpu_data_nxt    = 8'hFF;
                        w_cpu_data_en_nxt = 1'b1;
                        w_state_nxt       = S_HOLD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_HOLD: begin
                if (w_t1) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end

            default: begin
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
                w_io_rd_nxt  = 1'b0;
                w_io_wr_nxt  = 1'b0;
                w_ready_nxt  = 1'b1;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state       <= S_IDLE;
            r_lo          <= 8'd0;
            r_addr        <= 14'd0;
            r_cycle       <= 2'b00;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wdata   <= 8'd0;
            r_io_rd       <= 1'b0;
            r_io_wr       <= 1'b0;
            r_io_port     <= 5'd0;
            r_io_wdata    <= 8'd0;
            r_cpu_data    <= 8'd0;
            r_cpu_data_en <= 1'b0;
            r_ready       <= 1'b1;
            r_inta        <= 1'b0;
            r_halt        <= 1'b0;
            r_err         <= 1'b0;
            r_cnt         <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_lo          <= w_lo_nxt;
            r_addr        <= w_addr_nxt;
            r_cycle       <= w_cycle_nxt;
            r_mem_rd      <= w_mem_rd_nxt;
            r_mem_wr      <= w_mem_wr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_io_rd       <= w_io_rd_nxt;
            r_io_wr       <= w_io_wr_nxt;
            r_io_port     <= w_io_port_nxt;
            r_io_wdata    <= w_io_wdata_nxt;
            r_cpu_data    <= w_cpu_data_nxt;
            r_cpu_data_en <= w_cpu_data_en_nxt;
            r_ready       <= w_ready_nxt;
            r_inta        <= w_inta_nxt;
            r_halt        <= w_halt_nxt;
            r_err         <= w_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign READY_O       = r_ready;
    assign CPU_DATA_O    = r_cpu_data;
    assign CPU_DATA_EN_O = r_cpu_data_en;
    assign ADDR_O        = r_addr;
    assign CYCLE_O       = r_cycle;
    assign MEM_RD_O      = r_mem_rd;
    assign MEM_WR_O      = r_mem_wr;
    assign MEM_WDATA_O   = r_mem_wdata;
    assign IO_RD_O       = r_io_rd;
    assign IO_WR_O       = r_io_wr;
    assign IO_PORT_O     = r_io_port;
    assign IO_WDATA_O    = r_io_wdata;
    assign INTA_O        = r_inta;
    assign HALT_O        = r_halt;
    assign BUS_ERR_O     = r_err;

endmodule

// File: tb/tb_mcs8_bus_ctrl.sv
// Scoreboard bench for mcs8_bus_ctrl: a CPU-side driver issues bus cycles,
// a responder acknowledges requests after a chosen delay, and a monitor
// compares every request/data-return event against a queue of expectations.
`timescale 1ns/1ps
module tb_mcs8_bus_ctrl;

    localparam int WL = 4;
    localparam logic [2:0] T1 = 3'b010, T2 = 3'b100, T3 = 3'b001, T1I = 3'b110;
    localparam logic [2:0] STOP = 3'b011, WAITS = 3'b000;
    localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3, K_RET = 4;

    logic        CLK_I, RST_I, SYNC_I;
    logic [2:0]  STATE_I;
    logic [7:0]  BUS_I;
    logic        READY_O;
    logic [7:0]  CPU_DATA_O;
    logic        CPU_DATA_EN_O;
    logic [13:0] ADDR_O;
    logic [1:0]  CYCLE_O;
    logic        MEM_RD_O, MEM_WR_O;
    logic [7:0]  MEM_WDATA_O, MEM_RDATA_I;
    logic        MEM_ACK_I;
    logic        IO_RD_O, IO_WR_O;
    logic [4:0]  IO_PORT_O;
    logic [7:0]  IO_WDATA_O, IO_RDATA_I;
    logic        IO_ACK_I;
    logic [7:0]  INT_VEC_I;
    logic        INTA_O, HALT_O, BUS_ERR_O;

    typedef struct {
        int          kind;
        logic [13:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  ack_d  = 1;
    bit  exp_err = 1'b0;

    mcs8_bus_ctrl #(.WAIT_LIMIT(WL)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I), .BUS_I(BUS_I),
        .READY_O(READY_O), .CPU_DATA_O(CPU_DATA_O), .CPU_DATA_EN_O(CPU_DATA_EN_O),
        .ADDR_O(ADDR_O), .CYCLE_O(CYCLE_O), .MEM_RD_O(MEM_RD_O), .MEM_WR_O(MEM_WR_O),
        .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I), .MEM_ACK_I(MEM_ACK_I),
        .IO_RD_O(IO_RD_O), .IO_WR_O(IO_WR_O), .IO_PORT_O(IO_PORT_O), .IO_WDATA_O(IO_WDATA_O),
        .IO_RDATA_I(IO_RDATA_I), .IO_ACK_I(IO_ACK_I), .INT_VEC_I(INT_VEC_I),
        .INTA_O(INTA_O), .HALT_O(HALT_O), .BUS_ERR_O(BUS_ERR_O)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    // One CPU state: present inputs, let one rising edge sample them.
    task automatic drive(input logic s, input logic [2:0] st, input logic [7:0] b);
        SYNC_I  = s;
        STATE_I = st;
        BUS_I   = b;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic push(input int k, input logic [13:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    // Count stalled cycles until the CPU may proceed.
    task automatic wait_ready(output int n);
        n = 0;
        while (READY_O !== 1'b1 && n < 100) begin
            drive(1'b0, WAITS, 8'h00);
            n++;
        end
    endtask

    // A complete CPU bus cycle; d = ACK delay in cycles, 0 = never ACK.
    task automatic run_cycle(input logic [1:0] cyc, input logic [13:0] addr,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input int d, input bit intc);
        int          n;
        int          exp_stall;
        logic [4:0]  port;
        logic [7:0]  rdv;
        port = addr[13:9];
        rdv  = (d == 0) ? 8'hFF : rd;
        exp_stall = (d == 0) ? WL : d;
        case (cyc)
            2'b00, 2'b10: begin
                if (intc) begin
                    push(K_RET, 14'd0, rd);
                    exp_stall = 0;
                end else begin
                    push(K_MRD, addr, {6'd0, cyc});
                    push(K_RET, 14'd0, rdv);
                    if (d == 0) exp_err = 1'b1;
                end
            end
            2'b01: begin
                if (port < 5'd8) begin
                    push(K_IRD, {9'd0, port}, 8'd0);
                    push(K_RET, 14'd0, rdv);
                end else begin
                    push(K_IWR, {9'd0, port}, addr[7:0]);
                end
                if (d == 0) exp_err = 1'b1;
            end
            default: begin
                push(K_MWR, addr, wd);
                if (d == 0) exp_err = 1'b1;
            end
        endcase
        MEM_RDATA_I = rd;
        IO_RDATA_I  = rd;
        INT_VEC_I   = rd;
        ack_d       = d;
        drive(1'b1, intc ? T1I : T1, addr[7:0]);
        chk("inta_after_t1", {31'd0, INTA_O}, {31'd0, intc});
        drive(1'b1, T2, {cyc, addr[13:8]});
        if (cyc == 2'b11) begin
            drive(1'b1, T3, wd);
            wait_ready(n);
        end else begin
            wait_ready(n);
            drive(1'b1, T3, 8'h00);
        end
        chk("ready_stall_cycles", n, exp_stall);
        chk("bus_err", {31'd0, BUS_ERR_O}, {31'd0, exp_err});
    endtask

    // Memory/I/O responder: raise ACK so that the edge d cycles after the
    // request rises samples it.
    initial begin : responder
        int n;
        n = 0;
        MEM_ACK_I = 1'b0;
        IO_ACK_I  = 1'b0;
        forever begin
            @(posedge CLK_I);
            #1;
            if (MEM_RD_O || MEM_WR_O || IO_RD_O || IO_WR_O) begin
                n++;
                MEM_ACK_I = (ack_d != 0) && (n == ack_d) && (MEM_RD_O || MEM_WR_O);
                IO_ACK_I  = (ack_d != 0) && (n == ack_d) && (IO_RD_O || IO_WR_O);
            end else begin
                n = 0;
                MEM_ACK_I = 1'b0;
                IO_ACK_I  = 1'b0;
            end
        end
    end

    // Monitor: every rising request strobe or data-enable pops one expectation.
    initial begin : monitor
        logic [4:0]  prev_v;
        logic [4:0]  cur_v;
        logic [13:0] act_a;
        logic [7:0]  act_d;
        ev_t         e;
        prev_v = 5'd0;
        forever begin
            @(negedge CLK_I);
            cur_v = {CPU_DATA_EN_O, IO_WR_O, IO_RD_O, MEM_WR_O, MEM_RD_O};
            for (int k = 0; k < 5; k++) begin
                if (cur_v[k] === 1'b1 && prev_v[k] !== 1'b1) begin
                    case (k)
                        K_MRD:   begin act_a = ADDR_O;            act_d = {6'd0, CYCLE_O}; end
                        K_MWR:   begin act_a = ADDR_O;            act_d = MEM_WDATA_O;     end
                        K_IRD:   begin act_a = {9'd0, IO_PORT_O}; act_d = 8'd0;            end
                        K_IWR:   begin act_a = {9'd0, IO_PORT_O}; act_d = IO_WDATA_O;      end
                        default: begin act_a = 14'd0;             act_d = CPU_DATA_O;      end
                    endcase
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got kind %0d a=0x%0h d=0x%0h, nothing expected",
                                 k, act_a, act_d);
                    end else begin
                        e = exp_q.pop_front();
                        if (k != e.kind || act_a !== e.a || act_d !== e.d) begin
                            errors++;
                            $display("FAIL sb_event: got kind %0d a=0x%0h d=0x%0h expected kind %0d a=0x%0h d=0x%0h",
                                     k, act_a, act_d, e.kind, e.a, e.d);
                        end
                    end
                end
            end
            prev_v = cur_v;
        end
    end

    initial begin : stimulus
        int n;
        RST_I = 1'b1;
        SYNC_I = 1'b0; STATE_I = WAITS; BUS_I = 8'h00;
        MEM_RDATA_I = 8'h00; IO_RDATA_I = 8'h00; INT_VEC_I = 8'h00;
        drive(1'b0, WAITS, 8'h00);
        drive(1'b0, WAITS, 8'h00);
        chk("rst_ready", {31'd0, READY_O}, 32'd1);
        chk("rst_addr", {18'd0, ADDR_O}, 32'd0);
        chk("rst_cycle", {30'd0, CYCLE_O}, 32'd0);
        chk("rst_strobes", {28'd0, MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O}, 32'd0);
        chk("rst_wdata", {16'd0, MEM_WDATA_O, IO_WDATA_O}, 32'd0);
        chk("rst_port", {27'd0, IO_PORT_O}, 32'd0);
        chk("rst_cpu_data", {23'd0, CPU_DATA_EN_O, CPU_DATA_O}, 32'd0);
        chk("rst_flags", {29'd0, INTA_O, HALT_O, BUS_ERR_O}, 32'd0);
        RST_I = 1'b0;

        // Directed cycles from the test plan.
        run_cycle(2'b10, 14'h2A5C, 8'h00, 8'h3E, 3, 1'b0);
        run_cycle(2'b11, 14'h0100, 8'hA7, 8'h00, 1, 1'b0);
        run_cycle(2'b01, {6'h11, 8'h99}, 8'h00, 8'h00, 2, 1'b0);
        run_cycle(2'b01, {6'h0B, 8'h00}, 8'h00, 8'h12, 1, 1'b0);
        // ACK on the limit edge completes normally.
        run_cycle(2'b10, 14'h1234, 8'h00, 8'h6B, WL, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_cycle(2'($urandom_range(0, 3)), 14'($urandom), 8'($urandom),
                      8'($urandom), $urandom_range(1, 3), 1'b0);
        end

        // Timeout: no ACK, error is sticky across a following good cycle.
        run_cycle(2'b10, 14'h0123, 8'h00, 8'h55, 0, 1'b0);
        run_cycle(2'b00, 14'h3F00, 8'h00, 8'h21, 2, 1'b0);

        // Interrupt acknowledge then STOP.
        run_cycle(2'b00, 14'h0000, 8'h00, 8'h0D, 1, 1'b1);
        chk("inta_held", {31'd0, INTA_O}, 32'd1);
        drive(1'b1, STOP, 8'h00);
        chk("halt_set", {31'd0, HALT_O}, 32'd1);
        drive(1'b1, T1, 8'h00);
        chk("halt_clear", {31'd0, HALT_O}, 32'd0);
        chk("inta_clear", {31'd0, INTA_O}, 32'd0);

        // Reset while a read is outstanding.
        ack_d = 0;
        push(K_MRD, 14'h2A5C, 8'd2);
        drive(1'b1, T1, 8'h5C);
        drive(1'b1, T2, 8'hAA);
        drive(1'b0, WAITS, 8'h00);
        chk("pre_rst_rd", {31'd0, MEM_RD_O}, 32'd1);
        RST_I = 1'b1;
        drive(1'b0, WAITS, 8'h00);
        RST_I = 1'b0;
        exp_err = 1'b0;
        chk("mid_rst_strobes", {28'd0, MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O}, 32'd0);
        chk("mid_rst_ready", {31'd0, READY_O}, 32'd1);
        chk("mid_rst_addr", {18'd0, ADDR_O}, 32'd0);
        chk("mid_rst_err", {31'd0, BUS_ERR_O}, 32'd0);

        // A T1 sample while a request is outstanding aborts it.
        push(K_MRD, 14'h0A11, 8'd2);
        drive(1'b1, T1, 8'h11);
        drive(1'b1, T2, 8'h8A);
        drive(1'b0, WAITS, 8'h00);
        drive(1'b1, T1, 8'h00);
        chk("abort_rd", {31'd0, MEM_RD_O}, 32'd0);
        chk("abort_err", {31'd0, BUS_ERR_O}, 32'd1);
        chk("abort_ready", {31'd0, READY_O}, 32'd1);

        drive(1'b0, WAITS, 8'h00);
        drive(1'b0, WAITS, 8'h00);
        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcs8_bus_ctrl.md
Name: mcs8_bus_ctrl

Overview:
- System bus controller that sits directly downstream of the MCS8 CPU core.
- Demultiplexes the core's 8-bit time-multiplexed bus using its T-state code. It latches the 14-bit address and 2-bit cycle type, and runs handshaked memory and I/O transactions.
- Returns read or input data to the core during T3, and drives READY_O to stretch CPU cycles.
- Also reports interrupt acknowledge, halt and bus errors.

Parameters:
- WAIT_LIMIT, 255: maximum number of cycles a memory/IO request may stay outstanding before a timeout is declared. Range 1..255; the counter is 8 bits.

Ports:
- CLK_I  in  1  system clock; all logic is clocked on the rising edge.
- RST_I  in  1  synchronous reset, active high.
- SYNC_I  in  1  state strobe: exactly one CLK_I cycle per CPU state; BUS_I and STATE_I are sampled only when SYNC_I=1.
- STATE_I  in  3  CPU state code: T1=010, T2=100, T3=001, T4=111, T5=101, T1I=110, STOP=011, WAIT=000.
- BUS_I  in  8  CPU multiplexed output bus.
- READY_O  out  1  to CPU; 0 = stall.
- CPU_DATA_O  out  8  read/input data to CPU.
- CPU_DATA_EN_O  out  1  CPU_DATA_O valid (high during T3 of a read/input cycle).
- ADDR_O  out  14  latched address {hi[5:0], lo[7:0]}.
- CYCLE_O  out  2  latched cycle type: 00 PCI, 01 PCC, 10 PCR, 11 PCW.
- MEM_RD_O  out  1  memory read request.
- MEM_WR_O  out  1  memory write request.
- MEM_WDATA_O  out  8  memory write data.
- MEM_RDATA_I  in  8  memory read data.
- MEM_ACK_I  in  1  memory acknowledge.
- IO_RD_O  out  1  input-port request.
- IO_WR_O  out  1  output-port request.
- IO_PORT_O  out  5  port number.
- IO_WDATA_O  out  8  output-port data.
- IO_RDATA_I  in  8  input-port data.
- IO_ACK_I  in  1  I/O acknowledge.
- INT_VEC_I  in  8  instruction byte jammed in during an interrupt-acknowledge fetch.
- INTA_O  out  1  interrupt acknowledge.
- HALT_O  out  1  CPU is in STOP.
- BUS_ERR_O  out  1  sticky error flag.

Behaviour:
- Reset values: ADDR_O=0, CYCLE_O=00, all request strobes 0, MEM_WDATA_O=0, IO_WDATA_O=0, IO_PORT_O=0, CPU_DATA_O=0, CPU_DATA_EN_O=0, READY_O=1, INTA_O=0, HALT_O=0, BUS_ERR_O=0, FSM=IDLE.
- Reset asserted mid-transaction aborts it: every request strobe is 0 on the next edge.

T1 and T1I samples:
- T1 (or T1I): latch lo=BUS_I.
- T1I additionally sets INTA_O=1. INTA_O clears at the next T1.

T2 sample:
- Latch hi=BUS_I[5:0] and CYCLE_O=BUS_I[7:6].
- ADDR_O updates atomically on this edge.

Transaction dispatch on T2:
- PCI/PCR:
  - If INTA_O=1, capture INT_VEC_I with no memory request.
  - Otherwise go to RD_REQ: MEM_RD_O=1 from the next cycle.
- PCC:
  - IO_PORT_O=hi[5:1].
  - Port<8 is an input: IO_RD_O=1.
  - Port>=8 is an output: IO_WR_O=1 with IO_WDATA_O=lo.
- PCW: go to WR_ARM and wait for T3.

T3 sample in WR_ARM:
- MEM_WDATA_O=BUS_I; go to WR_REQ with MEM_WR_O=1.

Request handshake:
- A request holds until its ACK is sampled high. The request drops on the edge that samples ACK, so the minimum request width is 1 cycle.
- ACK while no request is outstanding is ignored.
- Read data is captured on the ACK edge. The FSM then goes to HOLD.

Data return:
- CPU_DATA_EN_O=1 with the captured data from the HOLD entry until the next T1 sample.
- Outside that window, CPU_DATA_O holds its value and CPU_DATA_EN_O=0.

READY_O:
- READY_O=0 from the dispatch edge (T2 for reads/IO, T3 for writes) until the ACK edge. Otherwise READY_O=1.
- A write stall therefore affects the next cycle's T2.

Timeout:
- An 8-bit counter is cleared on each request start and increments every cycle the request is held.
- When count==WAIT_LIMIT with no ACK:
  - drop the request;
  - set BUS_ERR_O=1;
  - for reads, capture 8'hFF;
  - set READY_O=1 and go to HOLD (IDLE for writes).

Other boundary rules:
- A T1 sample while a request is outstanding aborts it: the request drops, BUS_ERR_O=1, and the new cycle starts normally.
- An ACK in the same edge as the timeout takes priority over the timeout: normal completion, no error.
- HALT_O=1 on every sample with STATE_I=STOP; it clears on the next non-STOP sample.
- WAIT samples leave all state unchanged.
- SYNC_I=0 cycles advance only the handshake and timeout logic.
- BUS_ERR_O clears only on reset.

FSM states and transitions:
- IDLE -> RD_REQ / IO_REQ / WR_ARM on the T2 sample.
- WR_ARM -> WR_REQ on the T3 sample.
- RD_REQ, IO_REQ, WR_REQ -> HOLD on ACK or timeout.
- HOLD -> IDLE on the next T1 sample.

Test Plan:
- PCR read at 0x2A5C, MEM_ACK_I 3 cycles after MEM_RD_O, MEM_RDATA_I=0x3E -> ADDR_O=0x2A5C, CYCLE_O=10, READY_O low exactly 3 cycles, CPU_DATA_O=0x3E with EN high at T3.
- PCW to 0x0100 with BUS_I=0xA7 at T3, zero-wait ACK -> MEM_WR_O high 1 cycle, MEM_WDATA_O=0xA7, no error.
- PCC with T2 byte 0x51 (port 8) and T1 byte 0x99 -> IO_WR_O, IO_PORT_O=8, IO_WDATA_O=0x99. Then T2 byte 0x4B (port 5) with IO_RDATA_I=0x12 -> IO_RD_O, CPU_DATA_O=0x12.
- WAIT_LIMIT=4, read with no ACK -> MEM_RD_O drops after 4 cycles, BUS_ERR_O=1 (sticky), CPU_DATA_O=0xFF, READY_O=1.
- T1I then PCI with INT_VEC_I=0x0D -> INTA_O=1, no MEM_RD_O, CPU_DATA_O=0x0D. STOP state -> HALT_O=1.
- RST_I pulsed while MEM_RD_O is high -> next edge all strobes 0, READY_O=1, ADDR_O=0, BUS_ERR_O=0.
